// File: rtl/mux_pkg.sv
// Shared definitions for the streaming multiplexer slice: mode encodings,
// packet-lock FSM states and the constant log2 used to size select fields.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  // Ceiling log2, usable in parameter declarations.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority encoder: picks the first requesting channel after ptr,
// wrapping modulo NCH. Purely combinational.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            grant_valid
);

  // Search ptr+1, ptr+2, ... ptr+NCH; the first hit wins.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      if (!grant_valid && req[(32'(ptr) + i) % NCH]) begin
        grant       = SELW'((32'(ptr) + i) % NCH);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Channel choice is either an external select or round-robin.
// Optional packet lock (define MUX_PKT_LOCK_EN): once a packet starts, the
// channel keeps the grant until its in_last beat has been transferred.
module rr_stream_mux
  import mux_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef MUX_PKT_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  logic             load;
  logic             xfer;
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  rr_grant;
  logic             rr_valid;
  logic [SELW-1:0]  arb_idx;
  logic             arb_valid;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_arb (
    .req         (in_valid),
    .ptr         (ptr),
    .grant       (rr_grant),
    .grant_valid (rr_valid)
  );

  // Output register can take a new beat when empty or being drained.
  assign load = !out_valid || out_ready;

  // Mode-dependent grant: external select (range-checked) or round-robin.
  always_comb begin
    arb_idx   = '0;
    arb_valid = 1'b0;
    if (mode == MODE_RR) begin
      arb_idx   = rr_grant;
      arb_valid = rr_valid;
    end else if (32'(sel) < NCH) begin
      arb_idx   = sel;
      arb_valid = in_valid[sel];
    end
  end

`ifdef MUX_PKT_LOCK_EN
  lock_state_t     lock_state;
  logic [SELW-1:0] lock_ch;

  // A locked packet overrides both mode and sel until its last beat.
  always_comb begin
    grant_idx   = arb_idx;
    grant_valid = arb_valid;
    if (lock_state == ST_LOCKED) begin
      grant_idx   = lock_ch;
      grant_valid = in_valid[lock_ch];
    end
  end

  // Packet-lock FSM: lock on a non-last beat, release on the last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= ST_IDLE;
      lock_ch    <= '0;
    end else if (xfer) begin
      case (lock_state)
        ST_IDLE: begin
          if (!in_last[grant_idx]) begin
            lock_state <= ST_LOCKED;
            lock_ch    <= grant_idx;
          end
        end
        ST_LOCKED: begin
          if (in_last[grant_idx]) lock_state <= ST_IDLE;
        end
        default: lock_state <= ST_IDLE;
      endcase
    end
  end
`else
  assign grant_idx   = arb_idx;
  assign grant_valid = arb_valid;
`endif

  // A granted channel is always valid, so a grant plus load is a transfer.
  assign xfer       = load && grant_valid && !rst;
  assign grant_data = in_data[32'(grant_idx)*WIDTH +: WIDTH];

  // Ready is one-hot on the granted channel, or all zero.
  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[grant_idx] = 1'b1;
  end

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= SELW'(NCH - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        ptr       <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel streaming multiplexer: the registered, handshaked successor to the team's 4:1 combinational select mux. Selects one of `NCH` valid/ready input streams, either by an external select or by round-robin arbitration, and forwards one beat per cycle through a single output register stage. It sits between several producer channels and one shared consumer, such as a shared bus or output port.

## Interface
- `NCH`, 4: number of input channels, from 2 to 16.
- `WIDTH`, 8: data width per channel.
- `SELW`, `$clog2(NCH)`: derived width of the select and channel-id fields; not overridden.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  SELW  channel index used in fixed mode.
- `in_data`  in  NCH*WIDTH  channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `in_valid`  in  NCH  per-channel valid.
- `in_ready`  out  NCH  per-channel ready; one-hot or zero.
- `in_last`  in  NCH  end-of-packet flag per channel; present only with `MUX_PKT_LOCK_EN`.
- `out_data`  out  WIDTH  registered data.
- `out_valid`  out  1  registered valid.
- `out_ch`  out  SELW  index of the channel that sourced `out_data`.
- `out_ready`  in  1  consumer ready.

## Operation
- `load = !out_valid || out_ready`: the output register accepts a new beat this cycle.
- Grant, combinational:
  - Fixed mode: grant `sel` if `sel < NCH` and `in_valid[sel]`.
  - Round-robin mode: grant the first valid channel searching `ptr+1, ptr+2, …` modulo NCH.
  - Otherwise no grant.
- `in_ready[g] = load && grant_valid && !rst` for the granted channel g; all other bits are 0.
- A transfer occurs when `in_valid[g] && in_ready[g]`. On a transfer:
  - `out_data <= in_data[g]`, `out_ch <= g`, `out_valid <= 1`.
  - `ptr <= g`, in both modes.
- If `load` is high and there is no grant, `out_valid <= 0`. `out_data` and `out_ch` hold their values.
- If `out_valid && !out_ready`, all output registers hold and every `in_ready` is 0.
- Changing `mode` or `sel` takes effect in the same cycle's grant evaluation. The beat already held in the register is unaffected.
- Fairness: in round-robin mode with all NCH channels continuously valid, the grant order is 0, 1, …, NCH-1, 0, …
- Out-of-range `sel` (NCH not a power of two): no grant, no transfer, no error flag.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_ch` 0, `ptr` NCH-1 (so channel 0 wins first), lock FSM IDLE, `in_ready` all 0 while `rst` is high.
- Latency: a beat accepted in cycle t appears on `out_data`/`out_valid` in cycle t+1.
- Throughput: one beat per cycle when `out_ready` is held high.
- Combinational paths:
  - `out_ready` → `in_ready`.
  - `in_valid`, `mode`, `sel` → `in_ready`.
  - No combinational path from any input to `out_data`, `out_valid` or `out_ch`.
- Reset asserted mid-stream: the output beat is dropped (`out_valid` goes to 0 immediately), `ptr` and the lock are cleared. No beat is transferred while `rst` is high.

## Configuration
- `MUX_PKT_LOCK_EN` defined:
  - `in_last` port exists.
  - 2-state FSM: IDLE / LOCKED.
  - IDLE → LOCKED on a transfer with `in_last[g] = 0`; the locked channel is latched as g.
  - While LOCKED, the grant is the locked channel only, if valid. `mode` and `sel` are ignored.
  - LOCKED → IDLE on a transfer with `in_last = 1`.
  - A single-beat packet (`in_last = 1` on the first beat) stays in IDLE.
- `MUX_PKT_LOCK_EN` undefined: no `in_last` port, no FSM, arbitration every beat.

## Structure
- Shared package `mux_pkg`:
  - `MODE_FIXED = 1'b0`, `MODE_RR = 1'b1`.
  - Lock-FSM state encodings `ST_IDLE` / `ST_LOCKED`.
  - Constant clog2 function used to derive `SELW`.
- Sub-module `rr_arbiter`: parametrised `NCH` rotating-priority encoder.
  - Inputs: request vector, `ptr`.
  - Outputs: grant index, `grant_valid`.
  - Purely combinational.
- Top level holds the output register, `ptr`, the lock FSM and the fixed/round-robin grant select.

## Test plan
- Reset: NCH=4, WIDTH=8, all `in_valid = 1` during `rst` → `in_ready = 0000`, `out_valid = 0`, `out_data = 0x00`. After release in round-robin mode, the first beat out has `out_ch = 0`.
- Round-robin fairness: all 4 channels valid (data 0xA0+k), `out_ready = 1` for 8 cycles → `out_ch` sequence 0,1,2,3,0,1,2,3, one beat per cycle, 1-cycle latency.
- Fixed mode: `mode = 0`, `sel = 2`, channels 0 and 2 valid → only `in_ready[2] = 1`; `out_data = in_data[2]`. Changing `sel` to 0 mid-stream → the next beat comes from channel 0.
- Backpressure: `out_ready = 0` for 3 cycles with `out_valid = 1` → `out_data` stable, `in_ready = 0000`, no beats lost or duplicated when released (scoreboard check).
- Sparse requests in round-robin: only channels 1 and 3 valid → alternation 1,3,1,3. A channel-0 request arriving after grant 3 wins next.
- With `MUX_PKT_LOCK_EN`: channel 1 sends a 3-beat packet (`in_last` on beat 3) while channels 0 and 2 are valid → beats 1–3 all `out_ch = 1`, then arbitration resumes at channel 2. `rst` pulse mid-packet → lock cleared, next grant channel 0.
